ntt_bf_pe: RTL and testbench
============================

Name: ntt_bf_pe

Overview:
Parametrised, fully pipelined NTT/INTT butterfly processing element with a valid-tagged datapath. It supports per-operation selection between the Cooley-Tukey butterfly (forward NTT) and the Gentleman-Sande butterfly (inverse NTT), with optional divide-by-2 scaling of both outputs. It accepts one butterfly per cycle and sits between the coefficient memory read ports and the write-back path of the transform engine.

Parameters:
DATA_WIDTH, 12, coefficient width; must satisfy Q < 2^DATA_WIDTH.
Q, 3329, odd prime modulus.
MUL_LAT, 4, pipeline depth of the internal modular multiplier in cycles; minimum value is 1.

Ports:
clk  in  1  clock; all logic is on the rising edge.
rst  in  1  synchronous, active-low reset.
in_valid  in  1  marks u, v, w, mode and half_en as a valid operation this cycle.
mode  in  1  butterfly type: 0 = Cooley-Tukey (CT), 1 = Gentleman-Sande (GS).
half_en  in  1  when 1, both results are multiplied by 2^-1 mod Q.
u  in  DATA_WIDTH  upper operand, in the range [0, Q-1].
v  in  DATA_WIDTH  lower operand, in the range [0, Q-1].
w  in  DATA_WIDTH  twiddle factor, in the range [0, Q-1].
out_valid  out  1  marks bf_upper and bf_lower as valid.
bf_upper  out  DATA_WIDTH  upper butterfly result.
bf_lower  out  DATA_WIDTH  lower butterfly result.

Behaviour:
- Reset: when rst = 0 at a clock edge, every pipeline register, valid bit and output is cleared to 0 (out_valid = 0, bf_upper = 0, bf_lower = 0).
- Reset mid-operation: any in-flight operations are discarded and never emerge; inputs sampled while rst = 0 are ignored.
- Latency: L = MUL_LAT + 4 cycles from in_valid sampled high to out_valid high. L = 8 at the defaults.
- Throughput: one operation per cycle. There is no backpressure and no stall input.
- mode and half_en travel down the pipeline with their operands, so CT and GS operations may be mixed back-to-back.
- Pipeline stages:
  - S1: register the inputs, the valid bit and the per-operation tags.
  - S2 (CT): register a = u, b = v.
  - S2 (GS): register a = (u + v) mod Q, b = (u - v) mod Q.
  - M: t = (b * w) mod Q over MUL_LAT stages. Delay a by MUL_LAT stages alongside it.
  - S3 (CT): x = (a + t) mod Q, y = (a - t) mod Q.
  - S3 (GS): x = a, y = t.
  - S4: if half_en, replace each of x and y with h(z) = z >> 1 when z is even, else (z + Q) >> 1. Otherwise pass x and y through. Register the results onto bf_upper = x and bf_lower = y.
- Modular add: compute in DATA_WIDTH+1 bits; subtract Q if the sum is >= Q.
- Modular subtract: add Q if the difference is negative.
- Halving: (z + Q) must be computed in DATA_WIDTH+1 bits.
- Product: 2*DATA_WIDTH bits wide. Any internal reduction scheme is acceptable, provided the result is exact in [0, Q-1] at the stated latency.
- Bubbles: when in_valid = 0, out_valid goes low L cycles later. bf_upper and bf_lower hold their last valid values; they update only when out_valid is 1.
- Outputs are always in [0, Q-1] for in-range inputs. Out-of-range inputs give undefined data, but out_valid timing is unaffected.
- Boundary operands 0 and Q-1 must be exact; in particular (Q-1)*(Q-1) mod Q = 1.

Test Plan (Q = 3329, MUL_LAT = 4, L = 8):
- Reset, then CT with u=100, v=200, w=3, half_en=0 -> out_valid is 0 for 7 cycles, then high; bf_upper=700, bf_lower=2829.
- CT wrap-around cases:
  - u=3000, v=1000, w=1 -> bf_upper=671, bf_lower=2000.
  - u=0, v=3328, w=3328 -> bf_upper=1, bf_lower=3328.
- GS cases:
  - u=5, v=10, w=2, half_en=0 -> bf_upper=15, bf_lower=3319.
  - Same operands with half_en=1 -> bf_upper=1672, bf_lower=3324.
- Back-to-back stream of 4 operations alternating CT/GS, with a bubble after the second operation:
  - results emerge in order on consecutive cycles, matching a reference model;
  - out_valid shows the same single-cycle gap;
  - outputs hold their values during the gap.
- Reset mid-stream: pulse rst low for 1 cycle while 3 operations are in flight -> none of them emerges, outputs read 0, and the next operation issued after reset appears exactly 8 cycles later.
- Randomised mixed-mode soak of 10k operations with random half_en, including 0 and 3328 corner operands -> zero mismatches against the golden model.

Source files
------------

// File: rtl/ntt_bf_pe.sv
// Pipelined NTT/INTT butterfly: Cooley-Tukey or Gentleman-Sande per operation, optional halving.
// Operands ride down the pipe with their valid bit and mode/half tags; latency is MUL_LAT + 4.
module ntt_bf_pe #(
  parameter int unsigned DATA_WIDTH = 12,
  parameter int unsigned Q          = 3329,
  parameter int unsigned MUL_LAT    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic                  mode,
  input  logic                  half_en,
  input  logic [DATA_WIDTH-1:0] u,
  input  logic [DATA_WIDTH-1:0] v,
  input  logic [DATA_WIDTH-1:0] w,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] bf_upper,
  output logic [DATA_WIDTH-1:0] bf_lower
);

  localparam int unsigned DW = DATA_WIDTH;
  localparam int unsigned K  = 2 * DW;
  localparam int unsigned PW = 2 * DW + K + 1;

  localparam logic [DW:0]   QW       = (DW + 1)'(Q);
  localparam logic [PW-1:0] QP       = PW'(Q);
  // Barrett constant floor(2^K / Q); estimate is at most 2 short, hence two corrections.
  localparam logic [PW-1:0] BarrettM = (PW'(1) << K) / QP;

  function automatic logic [DW-1:0] mod_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= QW) s = s - QW;
    return DW'(s);
  endfunction

  function automatic logic [DW-1:0] mod_sub(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW:0] d;
    d = {1'b0, a} - {1'b0, b};
    if (a < b) d = d + QW;
    return DW'(d);
  endfunction

  function automatic logic [DW-1:0] halve(input logic [DW-1:0] z);
    logic [DW:0] s;
    s = {1'b0, z};
    if (z[0]) s = s + QW;
    return DW'(s >> 1);
  endfunction

  function automatic logic [DW-1:0] reduce(input logic [2*DW-1:0] p);
    logic [PW-1:0] qe;
    logic [PW-1:0] r;
    qe = (PW'(p) * BarrettM) >> K;
    r  = PW'(p) - qe * QP;
    if (r >= QP) r = r - QP;
    if (r >= QP) r = r - QP;
    return DW'(r);
  endfunction

  logic          vld1_q, mode1_q, half1_q;
  logic [DW-1:0] u1_q, v1_q, w1_q;
  logic          vld2_q, mode2_q, half2_q;
  logic [DW-1:0] a2_q, b2_q, w2_q, a2_d, b2_d;
  logic          vld_m_q  [MUL_LAT];
  logic          mode_m_q [MUL_LAT];
  logic          half_m_q [MUL_LAT];
  logic [DW-1:0] a_m_q    [MUL_LAT];
  logic [2*DW-1:0] prod, p_q;
  logic [DW-1:0] t_red, t_m, a_m;
  logic          vld3_q, half3_q;
  logic [DW-1:0] x3_q, y3_q, x3_d, y3_d, up_d, lo_d;

  assign prod  = (2 * DW)'(b2_q) * (2 * DW)'(w2_q);
  assign t_red = reduce(p_q);
  assign a_m   = a_m_q[MUL_LAT-1];

  // Product is registered in the first M stage; the reduced value fills the remaining stages.
  if (MUL_LAT == 1) begin : g_t_direct
    assign t_m = t_red;
  end else begin : g_t_pipe
    logic [DW-1:0] t_q [MUL_LAT-1];
    always_ff @(posedge clk) begin
      if (!rst) begin
        for (int i = 0; i < MUL_LAT - 1; i++) t_q[i] <= '0;
      end else begin
        t_q[0] <= t_red;
        for (int i = 1; i < MUL_LAT - 1; i++) t_q[i] <= t_q[i-1];
      end
    end
    assign t_m = t_q[MUL_LAT-2];
  end

  always_comb begin
    a2_d = u1_q;
    b2_d = v1_q;
    if (mode1_q) begin
      a2_d = mod_add(u1_q, v1_q);
      b2_d = mod_sub(u1_q, v1_q);
    end
    x3_d = a_m;
    y3_d = t_m;
    if (!mode_m_q[MUL_LAT-1]) begin
      x3_d = mod_add(a_m, t_m);
      y3_d = mod_sub(a_m, t_m);
    end
    up_d = half3_q ? halve(x3_q) : x3_q;
    lo_d = half3_q ? halve(y3_q) : y3_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      vld1_q    <= 1'b0;
      mode1_q   <= 1'b0;
      half1_q   <= 1'b0;
      u1_q      <= '0;
      v1_q      <= '0;
      w1_q      <= '0;
      vld2_q    <= 1'b0;
      mode2_q   <= 1'b0;
      half2_q   <= 1'b0;
      a2_q      <= '0;
      b2_q      <= '0;
      w2_q      <= '0;
      p_q       <= '0;
      for (int i = 0; i < MUL_LAT; i++) begin
        vld_m_q[i]  <= 1'b0;
        mode_m_q[i] <= 1'b0;
        half_m_q[i] <= 1'b0;
        a_m_q[i]    <= '0;
      end
      vld3_q    <= 1'b0;
      half3_q   <= 1'b0;
      x3_q      <= '0;
      y3_q      <= '0;
      out_valid <= 1'b0;
      bf_upper  <= '0;
      bf_lower  <= '0;
    end else begin
      vld1_q      <= in_valid;
      mode1_q     <= mode;
      half1_q     <= half_en;
      u1_q        <= u;
      v1_q        <= v;
      w1_q        <= w;
      vld2_q      <= vld1_q;
      mode2_q     <= mode1_q;
      half2_q     <= half1_q;
      a2_q        <= a2_d;
      b2_q        <= b2_d;
      w2_q        <= w1_q;
      p_q         <= prod;
      vld_m_q[0]  <= vld2_q;
      mode_m_q[0] <= mode2_q;
      half_m_q[0] <= half2_q;
      a_m_q[0]    <= a2_q;
      for (int i = 1; i < MUL_LAT; i++) begin
        vld_m_q[i]  <= vld_m_q[i-1];
        mode_m_q[i] <= mode_m_q[i-1];
        half_m_q[i] <= half_m_q[i-1];
        a_m_q[i]    <= a_m_q[i-1];
      end
      vld3_q      <= vld_m_q[MUL_LAT-1];
      half3_q     <= half_m_q[MUL_LAT-1];
      x3_q        <= x3_d;
      y3_q        <= y3_d;
      out_valid   <= vld3_q;
      // Results hold through bubbles.
      if (vld3_q) begin
        bf_upper <= up_d;
        bf_lower <= lo_d;
      end
    end
  end

endmodule

// File: tb/tb_ntt_bf_pe.sv
// Bench for ntt_bf_pe: directed vector table, stream/bubble and mid-stream reset sequences,
// then a mixed-mode soak checked cycle by cycle against an arithmetic reference.
module tb_ntt_bf_pe;
  localparam int DW = 12;
  localparam int Q  = 3329;
  localparam int ML = 4;
  localparam int L  = ML + 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          mode = 1'b0;
  logic          half_en = 1'b0;
  logic [DW-1:0] u = '0, v = '0, w = '0;
  logic          out_valid;
  logic [DW-1:0] bf_upper, bf_lower;

  always #5 clk = ~clk;

  ntt_bf_pe #(.DATA_WIDTH(DW), .Q(Q), .MUL_LAT(ML)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .mode     (mode),
    .half_en  (half_en),
    .u        (u),
    .v        (v),
    .w        (w),
    .out_valid(out_valid),
    .bf_upper (bf_upper),
    .bf_lower (bf_lower)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int hv(input int z);
    return (z % 2 == 0) ? z / 2 : (z + Q) / 2;
  endfunction

  function automatic void ref_bf(input logic m, input logic h, input int uu, input int vv,
                                 input int ww, output int x, output int y);
    int a, b, t;
    if (!m) begin
      a = uu;
      b = vv;
    end else begin
      a = (uu + vv) % Q;
      b = (uu - vv + Q) % Q;
    end
    t = (b * ww) % Q;
    if (!m) begin
      x = (a + t) % Q;
      y = (a - t + Q) % Q;
    end else begin
      x = a;
      y = t;
    end
    if (h) begin
      x = hv(x);
      y = hv(y);
    end
  endfunction

  typedef struct {
    logic vld;
    int   up;
    int   lo;
  } exp_t;

  exp_t pipe[$];
  logic mdl_vld;
  int   mdl_up, mdl_lo;

  task automatic model_reset();
    exp_t e;
    e.vld = 1'b0;
    e.up  = 0;
    e.lo  = 0;
    pipe.delete();
    for (int i = 0; i < L - 1; i++) pipe.push_back(e);
    mdl_vld = 1'b0;
    mdl_up  = 0;
    mdl_lo  = 0;
  endtask

  // One clock: drive at negedge, advance the reference at posedge, compare at next negedge.
  task automatic step(input logic r, input logic iv, input logic m, input logic h,
                      input int uu, input int vv, input int ww);
    exp_t e;
    rst = r;
    in_valid = iv;
    mode = m;
    half_en = h;
    u = 12'(uu);
    v = 12'(vv);
    w = 12'(ww);
    @(posedge clk);
    if (!r) begin
      model_reset();
    end else begin
      e.vld = iv;
      ref_bf(m, h, uu, vv, ww, e.up, e.lo);
      pipe.push_back(e);
      e = pipe.pop_front();
      mdl_vld = e.vld;
      if (e.vld) begin
        mdl_up = e.up;
        mdl_lo = e.lo;
      end
    end
    @(negedge clk);
    check("out_valid", out_valid, mdl_vld);
    check("bf_upper", bf_upper, mdl_up);
    check("bf_lower", bf_lower, mdl_lo);
  endtask

  function automatic int pick();
    int s;
    s = $urandom_range(0, 7);
    if (s == 0) return 0;
    if (s == 1) return Q - 1;
    return $urandom_range(0, Q - 1);
  endfunction

  typedef struct {
    logic m;
    logic h;
    int   uu, vv, ww;
    int   exp_up, exp_lo;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int low;
    int ops;
    logic iv;
    vecs[0] = '{1'b0, 1'b0, 100, 200, 3, 700, 2829};
    vecs[1] = '{1'b0, 1'b0, 3000, 1000, 1, 671, 2000};
    vecs[2] = '{1'b0, 1'b0, 0, 3328, 3328, 1, 3328};
    vecs[3] = '{1'b1, 1'b0, 5, 10, 2, 15, 3319};
    vecs[4] = '{1'b1, 1'b1, 5, 10, 2, 1672, 3324};
    vecs[5] = '{1'b0, 1'b1, 3328, 3328, 3328, 0, 3328};
    vecs[6] = '{1'b1, 1'b0, 3328, 0, 3328, 3328, 1};

    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("reset out_valid", out_valid, 0);
    check("reset bf_upper", bf_upper, 0);
    check("reset bf_lower", bf_lower, 0);
    rst = 1'b1;
    @(negedge clk);

    foreach (vecs[k]) begin
      in_valid = 1'b1;
      mode = vecs[k].m;
      half_en = vecs[k].h;
      u = 12'(vecs[k].uu);
      v = 12'(vecs[k].vv);
      w = 12'(vecs[k].ww);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      low = 0;
      while (!out_valid && low < 20) begin
        low++;
        @(negedge clk);
      end
      check("latency", low, L - 1);
      check("vec upper", bf_upper, vecs[k].exp_up);
      check("vec lower", bf_lower, vecs[k].exp_lo);
      @(negedge clk);
      check("valid pulse", out_valid, 0);
      check("hold upper", bf_upper, vecs[k].exp_up);
    end

    // Back-to-back mixed stream with a single bubble.
    step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 100, 200, 3);
    step(1'b1, 1'b1, 1'b1, 1'b1, 5, 10, 2);
    step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 3000, 1000, 1);
    step(1'b1, 1'b1, 1'b1, 1'b0, 0, 3328, 3328);
    repeat (L + 2) step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0);

    // Reset with three operations in flight; the input seen during reset is dropped.
    step(1'b1, 1'b1, 1'b0, 1'b0, 7, 9, 11);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1234, 2345, 3000);
    step(1'b1, 1'b1, 1'b0, 1'b1, 3328, 1, 17);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1, 2, 3);
    check("mid reset bf_upper", bf_upper, 0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 42, 17, 99);
    repeat (L + 2) step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0);

    ops = 0;
    while (ops < 10000) begin
      iv = ($urandom_range(0, 9) != 0);
      if (iv) ops++;
      step(1'b1, iv, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), pick(), pick(),
           pick());
    end
    repeat (L + 2) step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
